regs_wb_ctrl: RTL and testbench

REGS_WB_CTRL -- requirements
Module: regs_wb_ctrl

---
 rtl/regs_wb_ctrl.sv | 95 +++++++++
 tb/tb_regs_wb_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regs_wb_ctrl.sv
// rtl/regs_wb_ctrl.sv - writeback arbiter and register busy scoreboard
module regs_wb_ctrl #(
  parameter int XLEN      = 32,
  parameter int REG_COUNT = 32,
  parameter int AW        = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        req_valid,
  output logic [2:0]        req_ready,
  input  logic [3*AW-1:0]   req_addr,
  input  logic [3*XLEN-1:0] req_data,
  output logic              write_en,
  output logic [AW-1:0]     write_addr,
  output logic [XLEN-1:0]   write_data,
  input  logic              issue_valid,
  input  logic [AW-1:0]     issue_addr,
  output logic              issue_ready,
  input  logic [AW-1:0]     rd_addr1,
  output logic              rd_busy1,
  input  logic [AW-1:0]     rd_addr2,
  output logic              rd_busy2
);

  logic [REG_COUNT-1:0] busy;
  logic [REG_COUNT-1:0] busy_next;
  logic [1:0]           last_grant;
  logic [1:0]           grant_idx;
  logic [1:0]           idx;
  logic                 found;
  logic                 transfer;
  logic                 wb_hit;
  logic [AW-1:0]        gnt_addr;
  logic [XLEN-1:0]      gnt_data;

  function automatic logic [1:0] wrap_inc(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  // Round-robin search starting just after the last requester served
  always_comb begin
    req_ready = '0;
    grant_idx = 2'd0;
    found     = 1'b0;
    idx       = wrap_inc(last_grant);
    if (rst) begin
      for (int k = 0; k < 3; k++) begin
        if (!found && req_valid[idx]) begin
          found     = 1'b1;
          grant_idx = idx;
        end
        idx = wrap_inc(idx);
      end
    end
    if (found) req_ready[grant_idx] = 1'b1;
  end

  assign transfer = |(req_valid & req_ready);
  assign gnt_addr = req_addr[grant_idx*AW +: AW];
  assign gnt_data = req_data[grant_idx*XLEN +: XLEN];

  // A register being written back this cycle is free for a new reservation
  assign wb_hit      = write_en && (write_addr == issue_addr);
  assign issue_ready = rst && ((issue_addr == '0) || !busy[issue_addr] || wb_hit);

  assign rd_busy1 = (rd_addr1 != '0) && busy[rd_addr1];
  assign rd_busy2 = (rd_addr2 != '0) && busy[rd_addr2];

  // Set is applied after clear so a same-edge reservation wins
  always_comb begin
    busy_next = busy;
    if (write_en) busy_next[write_addr] = 1'b0;
    if (issue_valid && issue_ready && (issue_addr != '0)) busy_next[issue_addr] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy       <= '0;
      write_en   <= 1'b0;
      write_addr <= '0;
      write_data <= '0;
      last_grant <= 2'd2;
    end else begin
      busy     <= busy_next;
      write_en <= transfer && (gnt_addr != '0);
      if (transfer) begin
        write_addr <= gnt_addr;
        write_data <= gnt_data;
        last_grant <= grant_idx;
      end
    end
  end

endmodule

// File: tb/tb_regs_wb_ctrl.sv
// tb/tb_regs_wb_ctrl.sv - scoreboard bench for regs_wb_ctrl
module tb_regs_wb_ctrl;
  localparam int XLEN = 32;
  localparam int AW   = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic [2:0]        req_valid;
  logic [2:0]        req_ready;
  logic [3*AW-1:0]   req_addr;
  logic [3*XLEN-1:0] req_data;
  logic              write_en;
  logic [AW-1:0]     write_addr;
  logic [XLEN-1:0]   write_data;
  logic              issue_valid;
  logic [AW-1:0]     issue_addr;
  logic              issue_ready;
  logic [AW-1:0]     rd_addr1;
  logic              rd_busy1;
  logic [AW-1:0]     rd_addr2;
  logic              rd_busy2;

  int n_cmp = 0;
  int n_bad = 0;
  logic [AW+XLEN-1:0] exp_q[$];

  regs_wb_ctrl #(.XLEN(XLEN), .REG_COUNT(32), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data),
    .write_en(write_en), .write_addr(write_addr), .write_data(write_data),
    .issue_valid(issue_valid), .issue_addr(issue_addr), .issue_ready(issue_ready),
    .rd_addr1(rd_addr1), .rd_busy1(rd_busy1),
    .rd_addr2(rd_addr2), .rd_busy2(rd_busy2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every register file write must match the oldest expected write
  always @(negedge clk) begin
    if (write_en === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL wb_unexpected: got addr %0h data %0h expected no write", write_addr, write_data);
      end else begin
        logic [AW+XLEN-1:0] e;
        e = exp_q.pop_front();
        if ({write_addr, write_data} !== e) begin
          n_bad++;
          $display("FAIL wb_write: got %0h expected %0h", {write_addr, write_data}, e);
        end
      end
    end
  end

  task automatic idle();
    req_valid   = '0;
    req_addr    = '0;
    req_data    = '0;
    issue_valid = 1'b0;
    issue_addr  = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  logic [2:0]         exp_g[4] = '{3'b001, 3'b010, 3'b100, 3'b001};
  logic [AW+XLEN-1:0] exp_w[4] = '{{5'd1, 32'h11111111}, {5'd2, 32'h22222222},
                                   {5'd3, 32'h33333333}, {5'd1, 32'h11111111}};

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    idle();
    rd_addr1 = 5'd4;
    rd_addr2 = 5'd0;
    req_valid   = 3'b111;
    issue_valid = 1'b1;
    issue_addr  = 5'd4;
    repeat (2) @(posedge clk);
    sample();
    chk("rst_write_en", write_en, 0);
    chk("rst_write_addr", write_addr, 0);
    chk("rst_write_data", write_data, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_issue_ready", issue_ready, 0);
    chk("rst_rd_busy1", rd_busy1, 0);

    // Round-robin order with all three requesters valid
    next_cycle();
    rst = 1'b1;
    issue_valid = 1'b0;
    req_valid = 3'b111;
    req_addr  = {5'd3, 5'd2, 5'd1};
    req_data  = {32'h33333333, 32'h22222222, 32'h11111111};
    for (int i = 0; i < 4; i++) begin
      sample();
      chk("rr_grant", req_ready, exp_g[i]);
      exp_q.push_back(exp_w[i]);
      next_cycle();
    end
    idle();
    sample();
    chk("idle_req_ready", req_ready, 0);

    // Single request to a reserved register
    next_cycle();
    issue_valid = 1'b1;
    issue_addr  = 5'd5;
    rd_addr1    = 5'd5;
    sample();
    chk("x5_issue_ready", issue_ready, 1);
    chk("x5_busy_before", rd_busy1, 0);
    next_cycle();
    issue_valid = 1'b0;
    req_valid = 3'b001;
    req_addr  = {5'd0, 5'd0, 5'd5};
    req_data  = {64'd0, 32'hDEADBEEF};
    sample();
    chk("x5_grant", req_ready, 3'b001);
    chk("x5_busy_n", rd_busy1, 1);
    exp_q.push_back({5'd5, 32'hDEADBEEF});
    next_cycle();
    idle();
    sample();
    chk("x5_write_en", write_en, 1);
    chk("x5_busy_n1", rd_busy1, 1);
    next_cycle();
    sample();
    chk("x5_busy_n2", rd_busy1, 0);
    chk("hold_write_en", write_en, 0);
    chk("hold_write_addr", write_addr, 5'd5);
    chk("hold_write_data", write_data, 32'hDEADBEEF);

    // WAW stall on x7 and same-edge set-over-clear
    next_cycle();
    issue_valid = 1'b1;
    issue_addr  = 5'd7;
    rd_addr2    = 5'd7;
    sample();
    chk("x7_reserve", issue_ready, 1);
    next_cycle();
    req_valid = 3'b100;
    req_addr  = {5'd7, 10'd0};
    req_data  = {32'hCAFE0007, 64'd0};
    sample();
    chk("x7_waw_stall", issue_ready, 0);
    chk("x7_busy", rd_busy2, 1);
    chk("x7_grant", req_ready, 3'b100);
    exp_q.push_back({5'd7, 32'hCAFE0007});
    next_cycle();
    req_valid = 3'b000;
    sample();
    chk("x7_wb_bypass", issue_ready, 1);
    next_cycle();
    issue_valid = 1'b0;
    sample();
    chk("x7_set_wins", rd_busy2, 1);
    chk("x7_still_stall", issue_ready, 0);

    // Register x0 is never reserved and never written
    next_cycle();
    issue_valid = 1'b1;
    issue_addr  = 5'd0;
    rd_addr1    = 5'd0;
    req_valid   = 3'b010;
    req_addr    = '0;
    req_data    = {32'd0, 32'h0BAD0000, 32'd0};
    sample();
    chk("x0_issue_ready", issue_ready, 1);
    chk("x0_grant", req_ready, 3'b010);
    next_cycle();
    idle();
    sample();
    chk("x0_write_en", write_en, 0);
    chk("x0_busy", rd_busy1, 0);

    // Reset in the middle of activity
    next_cycle();
    issue_valid = 1'b1;
    issue_addr  = 5'd3;
    sample();
    chk("x3_reserve", issue_ready, 1);
    next_cycle();
    issue_addr = 5'd9;
    sample();
    chk("x9_reserve", issue_ready, 1);
    next_cycle();
    issue_valid = 1'b0;
    req_valid = 3'b010;
    req_addr  = {5'd0, 5'd9, 5'd0};
    req_data  = {32'd0, 32'h99999999, 32'd0};
    rd_addr1  = 5'd3;
    rd_addr2  = 5'd9;
    sample();
    chk("x9_grant", req_ready, 3'b010);
    chk("x3_busy", rd_busy1, 1);
    chk("x9_busy", rd_busy2, 1);
    exp_q.push_back({5'd9, 32'h99999999});
    next_cycle();
    rst = 1'b0;
    req_valid = 3'b111;
    req_addr  = {5'd12, 5'd11, 5'd10};
    req_data  = {32'h0000000C, 32'h0000000B, 32'h0000000A};
    issue_valid = 1'b1;
    issue_addr  = 5'd4;
    sample();
    chk("mid_rst_req_ready", req_ready, 0);
    chk("mid_rst_issue_ready", issue_ready, 0);
    next_cycle();
    rst = 1'b1;
    issue_valid = 1'b0;
    sample();
    chk("post_rst_write_en", write_en, 0);
    chk("post_rst_busy3", rd_busy1, 0);
    chk("post_rst_busy9", rd_busy2, 0);
    chk("post_rst_grant", req_ready, 3'b001);
    exp_q.push_back({5'd10, 32'h0000000A});
    next_cycle();
    idle();
    sample();
    next_cycle();
    sample();
    chk("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
